// File: rtl/spi_packet_pkg.sv
// Shared framing constants and state/error encodings for the SPI packet link.
// The packet transmitter imports SYNC_WORD from here as well.
package spi_packet_pkg;

  localparam logic [31:0] SYNC_WORD         = 32'h55AA55AA;
  localparam logic [15:0] TIMEOUT_LIMIT_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RECV_ADDR,
    RECV_LEN,
    RECV_ID,
    CHECK_HDR,
    RECV_DATA,
    CHECK_DATA,
    ERROR
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_HDR_CRC  = 3'd1,
    ERR_LEN      = 3'd2,
    ERR_DATA_CRC = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } err_t;

endpackage

// File: rtl/crc.sv
// Word-wide CRC-32 engine (poly 0x04C11DB7, MSB first, init all-ones, no final xor).
// rst is a synchronous clear; crc_out covers every word enabled on earlier cycles.
module crc (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [31:0] data_in,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = (r[31] ^ d[i]) ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  logic [31:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst)         r_crc <= INIT;
    else if (crc_en) r_crc <= crc_next(r_crc, data_in);
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/spi_packet_rx.sv
// Receive-side deframer: hunts SYNC, captures and CRC-checks the header, forwards
// the payload with zero-latency valid/ready passthrough and checks the data CRC.
module spi_packet_rx
  import spi_packet_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_enable,
  input  logic [31:0] rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        data_out_last,
  output logic [31:0] rx_base_addr,
  output logic [31:0] rx_length,
  output logic [15:0] rx_id,
  output logic [15:0] rx_packet_type,
  output logic        hdr_valid,
  output logic        pkt_done,
  output logic        receiving,
  output logic        error,
  output logic [2:0]  err_code
);

  state_t      r_state;
  err_t        r_err_code;
  logic [31:0] r_rx_base_addr;
  logic [31:0] r_rx_length;
  logic [15:0] r_rx_id;
  logic [15:0] r_rx_packet_type;
  logic [29:0] r_data_cnt;
  logic [15:0] r_timeout;
  logic        r_hdr_valid;
  logic        r_pkt_done;

  logic        w_accept;
  logic        w_last;
  logic        w_hdr_en;
  logic        w_data_en;
  logic        w_crc_clr;
  logic [31:0] w_hdr_crc;
  logic [31:0] w_data_crc;

  always_comb begin
    rx_data_ready = 1'b1;
    if (r_state == RECV_DATA)  rx_data_ready = data_out_ready;
    else if (r_state == ERROR) rx_data_ready = 1'b0;
  end

  assign w_accept  = rx_data_valid && rx_data_ready;
  assign w_last    = (r_state == RECV_DATA) && (r_data_cnt == r_rx_length[31:2] - 30'd1);
  assign w_hdr_en  = w_accept && (r_state == RECV_ADDR || r_state == RECV_LEN || r_state == RECV_ID);
  assign w_data_en = w_accept && (r_state == RECV_DATA);
  assign w_crc_clr = (r_state == IDLE);

  crc u_hdr_crc (
    .clk     (clk),
    .rst     (w_crc_clr),
    .crc_en  (w_hdr_en),
    .data_in (rx_data),
    .crc_out (w_hdr_crc)
  );

  crc u_data_crc (
    .clk     (clk),
    .rst     (w_crc_clr),
    .crc_en  (w_data_en),
    .data_in (rx_data),
    .crc_out (w_data_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_err_code       <= ERR_NONE;
      r_rx_base_addr   <= '0;
      r_rx_length      <= '0;
      r_rx_id          <= '0;
      r_rx_packet_type <= '0;
      r_data_cnt       <= '0;
      r_timeout        <= '0;
      r_hdr_valid      <= 1'b0;
      r_pkt_done       <= 1'b0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
      if (!rx_enable) begin
        r_state    <= IDLE;
        r_data_cnt <= '0;
        r_timeout  <= '0;
      end else if (r_state != IDLE && r_state != ERROR && r_timeout == TIMEOUT_LIMIT) begin
        r_state    <= ERROR;
        r_err_code <= ERR_TIMEOUT;
      end else begin
        // Inactivity counter runs between accepts and freezes for the ERROR cycle.
        if (r_state == IDLE || w_accept) r_timeout <= '0;
        else if (r_state != ERROR)       r_timeout <= r_timeout + 16'd1;

        case (r_state)
          IDLE: begin
            r_data_cnt <= '0;
            if (w_accept && rx_data == SYNC_WORD) begin
              r_state    <= RECV_ADDR;
              r_err_code <= ERR_NONE;
            end
          end
          RECV_ADDR: if (w_accept) begin
            r_rx_base_addr <= rx_data;
            r_state        <= RECV_LEN;
          end
          RECV_LEN: if (w_accept) begin
            r_rx_length <= rx_data;
            r_state     <= RECV_ID;
          end
          RECV_ID: if (w_accept) begin
            r_rx_packet_type <= rx_data[31:16];
            r_rx_id          <= rx_data[15:0];
            r_state          <= CHECK_HDR;
          end
          CHECK_HDR: if (w_accept) begin
            if (rx_data != w_hdr_crc) begin
              r_state    <= ERROR;
              r_err_code <= ERR_HDR_CRC;
            end else if (r_rx_length == '0 || r_rx_length[1:0] != 2'b00) begin
              r_state    <= ERROR;
              r_err_code <= ERR_LEN;
            end else begin
              r_state     <= RECV_DATA;
              r_hdr_valid <= 1'b1;
            end
          end
          RECV_DATA: if (w_accept) begin
            r_data_cnt <= r_data_cnt + 30'd1;
            if (w_last) r_state <= CHECK_DATA;
          end
          CHECK_DATA: if (w_accept) begin
            if (rx_data == w_data_crc) begin
              r_state    <= IDLE;
              r_pkt_done <= 1'b1;
            end else begin
              r_state    <= ERROR;
              r_err_code <= ERR_DATA_CRC;
            end
          end
          ERROR:   r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_out       = rx_data;
  assign data_out_valid = rx_data_valid && (r_state == RECV_DATA);
  assign data_out_last  = w_last;
  assign rx_base_addr   = r_rx_base_addr;
  assign rx_length      = r_rx_length;
  assign rx_id          = r_rx_id;
  assign rx_packet_type = r_rx_packet_type;
  assign hdr_valid      = r_hdr_valid;
  assign pkt_done       = r_pkt_done;
  assign receiving      = (r_state != IDLE);
  assign error          = (r_state == ERROR);
  assign err_code       = r_err_code;

endmodule

// File: tb/tb_spi_packet_rx.sv
// Scoreboard bench for spi_packet_rx: a packet-level model predicts header, payload,
// completion and error events; an independent monitor checks what the DUT presents.
module tb_spi_packet_rx;
  import spi_packet_pkg::*;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_enable = 1'b1;
  logic [31:0] rx_data = '0;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;
  logic        data_out_last;
  logic [31:0] rx_base_addr, rx_length;
  logic [15:0] rx_id, rx_packet_type;
  logic        hdr_valid, pkt_done, receiving, error;
  logic [2:0]  err_code;

  spi_packet_rx dut (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .data_out_last(data_out_last), .rx_base_addr(rx_base_addr), .rx_length(rx_length),
    .rx_id(rx_id), .rx_packet_type(rx_packet_type), .hdr_valid(hdr_valid),
    .pkt_done(pkt_done), .receiving(receiving), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 header, 1 packet done, 2 error
    int          code;
    logic [31:0] addr;
    logic [31:0] len;
    logic [15:0] id;
    logic [15:0] typ;
  } evt_t;

  logic [32:0] exp_data[$];
  evt_t        exp_evt[$];
  logic [31:0] pkt_q[$];
  int          n_total = 0;
  int          n_pass = 0;
  bit          hold_low = 1'b0;
  bit          rand_ready = 1'b0;
  bit          chk_after_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: unexpected or missing event", name);
  endtask

  // Reference CRC-32 over pkt_q[lo..hi], processed one message bit at a time.
  function automatic logic [31:0] crc_range(input int lo, input int hi);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int k = lo; k <= hi; k++)
      for (int b = 31; b >= 0; b--) begin
        fb = c[31] ^ pkt_q[k][b];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    return c;
  endfunction

  task automatic push_evt(input int kind, input int code);
    evt_t e;
    e.kind = kind; e.code = code;
    e.addr = pkt_q.size() > 1 ? pkt_q[1] : '0;
    e.len  = pkt_q.size() > 2 ? pkt_q[2] : '0;
    e.id   = pkt_q.size() > 3 ? pkt_q[3][15:0] : '0;
    e.typ  = pkt_q.size() > 3 ? pkt_q[3][31:16] : '0;
    exp_evt.push_back(e);
  endtask

  // Packet-level model: decides the outcome of pkt_q from the framing rules.
  task automatic model_packet(output int n_send);
    int n;
    n_send = 5;
    if (pkt_q[4] !== crc_range(1, 3)) begin push_evt(2, 1); return; end
    if (pkt_q[2] == 0 || pkt_q[2] % 4 != 0) begin push_evt(2, 2); return; end
    push_evt(0, 0);
    n = int'(pkt_q[2] / 4);
    for (int i = 0; i < n; i++) exp_data.push_back({(i == n - 1), pkt_q[5 + i]});
    if (pkt_q[5 + n] !== crc_range(5, 4 + n)) push_evt(2, 3);
    else push_evt(1, 0);
    n_send = 6 + n;
  endtask

  task automatic build(input logic [31:0] addr, input logic [31:0] len, input logic [15:0] id,
                       input logic [15:0] typ, input int nwords, input bit counting);
    pkt_q.delete();
    pkt_q.push_back(SYNC_WORD);
    pkt_q.push_back(addr);
    pkt_q.push_back(len);
    pkt_q.push_back({typ, id});
    pkt_q.push_back(crc_range(1, 3));
    for (int i = 0; i < nwords; i++) pkt_q.push_back(counting ? 32'(i + 1) : $urandom);
    pkt_q.push_back(crc_range(5, 4 + nwords));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    rx_data = w; rx_data_valid = 1'b1;
    while (!acc) begin
      @(negedge clk); acc = rx_data_ready;
      tick();
      n++;
      if (!acc && n > 2000) begin
        $display("FAIL send_stuck: word 0x%0h never accepted", w);
        $fatal(1, "bench stopped");
      end
    end
    rx_data_valid = 1'b0;
    rx_data = $urandom;
  endtask

  task automatic send_pkt(input int gap_max, input int stall_idx);
    int n_send;
    model_packet(n_send);
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      if (i == stall_idx) begin
        hold_low = 1'b1;
        rx_data = pkt_q[i]; rx_data_valid = 1'b1;
        repeat (100) tick();
        hold_low = 1'b0;
      end
      send_word(pkt_q[i]);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || exp_evt.size() != 0) && n < budget) begin tick(); n++; end
    check("drain_data_left", 64'(exp_data.size()), 64'd0);
    check("drain_evt_left", 64'(exp_evt.size()), 64'd0);
    exp_data.delete(); exp_evt.delete();
    tick(); tick();
  endtask

  always begin
    @(posedge clk); #2;
    data_out_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) if (rst_n) begin
    evt_t e;
    logic [32:0] d;
    if (chk_after_err) begin
      check("error_one_cycle", 64'(error), 64'd0);
      check("idle_after_error", 64'(receiving), 64'd0);
      chk_after_err = 1'b0;
    end
    if (data_out_valid && data_out_ready) begin
      if (exp_data.size() == 0) fail_now("data_unexpected");
      else begin d = exp_data.pop_front(); check("data_word", 64'({data_out_last, data_out}), 64'(d)); end
    end
    if (hdr_valid) begin
      if (exp_evt.size() == 0) fail_now("hdr_unexpected");
      else begin
        e = exp_evt.pop_front();
        check("hdr_kind", 64'd0, 64'(e.kind));
        check("hdr_fields", {rx_base_addr, rx_length[15:0], rx_id ^ rx_packet_type},
              {e.addr, e.len[15:0], e.id ^ e.typ});
        check("hdr_id_type", 64'({rx_packet_type, rx_id}), 64'({e.typ, e.id}));
      end
    end
    if (pkt_done) begin
      if (exp_evt.size() == 0) fail_now("done_unexpected");
      else begin
        e = exp_evt.pop_front();
        check("done_kind", 64'd1, 64'(e.kind));
        check("done_err_code", 64'(err_code), 64'd0);
      end
    end
    if (error) begin
      if (exp_evt.size() == 0) fail_now("error_unexpected");
      else begin
        e = exp_evt.pop_front();
        check("error_kind", 64'd2, 64'(e.kind));
        check("error_code", 64'(err_code), 64'(e.code));
      end
      chk_after_err = 1'b1;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(rx_data_ready), 64'd1);
    check("rst_receiving", 64'(receiving), 64'd0);
    check("rst_flags", 64'({hdr_valid, pkt_done, error, err_code}), 64'd0);
    check("rst_fields", {rx_base_addr, rx_length}, 64'd0);
    check("rst_id_type", 64'({rx_id, rx_packet_type}), 64'd0);

    // Loopback packet, back-to-back words.
    build(32'h1000_0000, 32'd16, 16'h0007, 16'h0002, 4, 1'b1);
    send_pkt(0, -1);
    drain(200);
    check("loop_err_code", 64'(err_code), 64'd0);

    // Garbage before SYNC is dropped.
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    build($urandom, 32'd12, 16'h1234, 16'h0001, 3, 1'b0);
    send_pkt(1, -1);
    drain(200);

    // Header CRC corrupted.
    build(32'hA000_0000, 32'd8, 16'h0003, 16'h0004, 2, 1'b0);
    pkt_q[4] = pkt_q[4] ^ 32'h1;
    send_pkt(0, -1);
    drain(200);

    // Length not a multiple of four.
    build(32'hB000_0000, 32'd6, 16'h0005, 16'h0001, 0, 1'b0);
    send_pkt(0, -1);
    drain(200);
    check("len_err_held", 64'(err_code), 64'd2);

    // Payload word flipped: all words forwarded, data CRC error.
    build(32'hC000_0000, 32'd16, 16'h0009, 16'h0002, 4, 1'b0);
    pkt_q[5] = pkt_q[5] ^ 32'h1;
    send_pkt(0, -1);
    drain(200);

    // Stall after LEN until the inactivity timeout fires.
    send_word(SYNC_WORD);
    send_word(32'hD000_0000);
    send_word(32'd16);
    pkt_q.delete();
    push_evt(2, 4);
    drain(70000);

    // Downstream backpressure for 100 cycles mid-payload: no timeout.
    build(32'hE000_0000, 32'd16, 16'h000A, 16'h0003, 4, 1'b0);
    send_pkt(0, 7);
    drain(300);

    // rx_enable dropped during payload: abandoned silently.
    build(32'hF000_0000, 32'd16, 16'h000B, 16'h0003, 4, 1'b0);
    push_evt(0, 0);
    exp_data.push_back({1'b0, pkt_q[5]});
    exp_data.push_back({1'b0, pkt_q[6]});
    for (int i = 0; i < 7; i++) send_word(pkt_q[i]);
    rx_enable = 1'b0;
    tick();
    rx_enable = 1'b1;
    check("enable_drop_idle", 64'(receiving), 64'd0);
    check("enable_drop_no_err", 64'({error, err_code}), 64'd0);
    drain(50);
    build(32'h0000_1000, 32'd8, 16'h000C, 16'h0001, 2, 1'b0);
    send_pkt(0, -1);
    drain(200);

    // Randomised packets with random backpressure, gaps and corruption.
    rand_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      int mode;
      int nw;
      mode = $urandom_range(0, 5);
      nw   = $urandom_range(1, 8);
      if ($urandom_range(0, 1) == 1) send_word($urandom | 32'h1);
      build($urandom, 32'(nw * 4), 16'($urandom), 16'($urandom), nw, 1'b0);
      if (mode == 3) pkt_q[$urandom_range(1, 4)] ^= (32'h1 << $urandom_range(0, 31));
      if (mode == 4) pkt_q[$urandom_range(5, 5 + nw)] ^= (32'h1 << $urandom_range(0, 31));
      send_pkt(2, -1);
    end
    drain(2000);
    rand_ready = 1'b0;
    check("end_idle", 64'(receiving), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
